// File: rtl/msg_sched_pkg.sv
// Shared types, default parameters and round-robin pick helper for msg_scheduler.
package msg_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REPORT
    } state_t;

    localparam int unsigned DEF_N_REQ   = 2;
    localparam int unsigned DEF_WORD_W  = 8;
    localparam int unsigned DEF_RUN_LEN = 4;
    localparam int unsigned MAX_REQ     = 8;

    // Walk downward so the candidate closest after last_id is the final one to stick.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         last_id,
                                           input int unsigned        n);
        logic [2:0]  pick;
        int unsigned idx;
        pick = last_id;
        for (int unsigned i = n; i >= 1; i--) begin
            idx = (32'(last_id) + i) % n;
            if (req[idx[2:0]]) pick = idx[2:0];
        end
        return pick;
    endfunction

endpackage

// File: rtl/msg_scheduler_if.sv
// Requester/result bus of msg_scheduler: word requests in, grant, bit stream and results out.
interface msg_scheduler_if
    import msg_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned WORD_W  = DEF_WORD_W,
    parameter int unsigned RUN_LEN = DEF_RUN_LEN
);
    localparam int unsigned ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int unsigned HIT_W = $clog2(WORD_W / RUN_LEN + 1);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*WORD_W-1:0] data;
    logic [N_REQ-1:0]        grant;
    logic                    busy;
    logic                    bit_out;
    logic                    bit_valid;
    logic                    done;
    logic [ID_W-1:0]         done_id;
    logic [HIT_W-1:0]        hit_count;

    modport master (
        output req, data,
        input  grant, busy, bit_out, bit_valid, done, done_id, hit_count
    );

    modport slave (
        input  req, data,
        output grant, busy, bit_out, bit_valid, done, done_id, hit_count
    );

endinterface

// File: rtl/msg_scheduler_run_detector.sv
// Non-overlapping run-of-ones detector; counts runs of RUN_LEN ones in a serial bit stream.
module run_detector #(
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned HIT_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             hit_pulse,
    output logic [HIT_W-1:0] hit_cnt
);
    localparam int unsigned RUN_W = $clog2(RUN_LEN);

    logic [RUN_W-1:0] run;

    assign hit_pulse = bit_valid && bit_in && (run == RUN_W'(RUN_LEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run     <= '0;
            hit_cnt <= '0;
        end else if (clear) begin
            run     <= '0;
            hit_cnt <= '0;
        end else if (bit_valid) begin
            if (!bit_in) begin
                run <= '0;
            end else if (hit_pulse) begin
                run     <= '0;
                hit_cnt <= hit_cnt + 1'b1;
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/msg_scheduler.sv
// Round-robin scheduler sharing one serial run detector among N_REQ parallel-word requesters.
module msg_scheduler
    import msg_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned WORD_W  = DEF_WORD_W,
    parameter int unsigned RUN_LEN = DEF_RUN_LEN
) (
    input  logic           clk,
    input  logic           reset,
    msg_scheduler_if.slave bus
);
    localparam int unsigned ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int unsigned HIT_W = $clog2(WORD_W / RUN_LEN + 1);
    localparam int unsigned CNT_W = $clog2(WORD_W);

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bitcnt;
    logic [ID_W-1:0]   cur_id;
    logic [ID_W-1:0]   last_id;
    logic [ID_W-1:0]   win_id;
    logic [N_REQ-1:0]  grant;
    logic              busy;
    logic              bit_valid;
    logic              done;
    logic [ID_W-1:0]   done_id;
    logic [HIT_W-1:0]  hit_count;
    logic              clear;
    logic              hit_pulse;
    logic [HIT_W-1:0]  hit_cnt;

    assign win_id = ID_W'(rr_pick(8'(bus.req), 3'(last_id), N_REQ));
    assign clear  = (state == IDLE) && (|bus.req);

    assign bus.grant     = grant;
    assign bus.busy      = busy;
    assign bus.bit_out   = shreg[WORD_W-1];
    assign bus.bit_valid = bit_valid;
    assign bus.done      = done;
    assign bus.done_id   = done_id;
    assign bus.hit_count = hit_count;

    run_detector #(
        .RUN_LEN (RUN_LEN),
        .HIT_W   (HIT_W)
    ) u_det (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .bit_valid (bit_valid),
        .bit_in    (shreg[WORD_W-1]),
        .hit_pulse (hit_pulse),
        .hit_cnt   (hit_cnt)
    );

    // The shift register empties to zero by the end of SHIFT, which keeps bit_out low when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            hit_count <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            cur_id    <= '0;
            last_id   <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (|bus.req) begin
                        grant     <= N_REQ'(1) << win_id;
                        shreg     <= bus.data[win_id*WORD_W +: WORD_W];
                        cur_id    <= win_id;
                        last_id   <= win_id;
                        bitcnt    <= '0;
                        busy      <= 1'b1;
                        bit_valid <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    grant  <= '0;
                    shreg  <= shreg << 1;
                    bitcnt <= bitcnt + 1'b1;
                    if (bitcnt == CNT_W'(WORD_W - 1)) begin
                        // Fold in the last bit's hit, which the detector only registers on this edge.
                        state     <= REPORT;
                        bit_valid <= 1'b0;
                        done      <= 1'b1;
                        done_id   <= cur_id;
                        hit_count <= hit_cnt + HIT_W'(hit_pulse);
                    end
                end
                REPORT: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_scheduler.sv
// Directed and randomized bench for msg_scheduler against a run-length / round-robin reference model.
module tb_msg_scheduler;
    localparam int N  = 2;
    localparam int W  = 8;
    localparam int RL = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   mlast;
    int   last_wait;
    longint last_g = 0;

    always #5 clk = ~clk;

    msg_scheduler_if #(.N_REQ(N), .WORD_W(W), .RUN_LEN(RL)) bif ();

    msg_scheduler #(.N_REQ(N), .WORD_W(W), .RUN_LEN(RL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each maximal run of ones of length L yields floor(L/RL) detections.
    function automatic int model_hits(input logic [W-1:0] w);
        int len = 0;
        int h = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (w[i]) len++;
            else begin
                h += len / RL;
                len = 0;
            end
        end
        return h + len / RL;
    endfunction

    function automatic int model_pick(input logic [N-1:0] rq);
        for (int k = 1; k <= N; k++)
            if (rq[(mlast + k) % N]) return (mlast + k) % N;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_word(input logic [N-1:0] rq, input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input bit drop, input bit chk_gap);
        int id;
        int hit;
        int vcnt;
        bit got;
        logic [W-1:0] w;
        logic [W-1:0] seen;
        bif.req  = rq;
        bif.data = {w1, w0};
        id  = model_pick(rq);
        w   = (id == 1) ? w1 : w0;
        hit = model_hits(w);
        got = 1'b0;
        last_wait = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            tick();
            last_wait++;
            if (bif.grant != '0) got = 1'b1;
        end
        check("grant_seen", 32'(got), 1);
        if (!got) return;
        check("grant", 32'(bif.grant), 32'(1 << id));
        if (chk_gap) check("grant_gap", 32'($time - last_g), 100);
        last_g = $time;
        mlast  = id;
        if (drop) bif.req[id] = 1'b0;
        bif.data = 16'($urandom);
        vcnt = 0;
        for (int k = 0; k < W; k++) begin
            if (k > 0) tick();
            if (k == 1) check("grant_one_cycle", 32'(bif.grant), 0);
            seen[W-1-k] = bif.bit_out;
            if (bif.bit_valid && bif.busy && !bif.done) vcnt++;
        end
        check("bits", 32'(seen), 32'(w));
        check("valid_cycles", 32'(vcnt), W);
        tick();
        check("done", 32'({bif.done, bif.busy, bif.bit_valid}), 32'(3'b110));
        check("done_id", 32'(bif.done_id), 32'(id));
        check("hit_count", 32'(bif.hit_count), 32'(hit));
        tick();
        check("after_done", 32'({bif.done, bif.busy, bif.done_id, bif.hit_count}),
              32'({1'b0, 1'b0, 1'(id), 2'(hit)}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        bit got;
        logic [N-1:0] rq;
        reset    = 1'b0;
        bif.req  = 2'b11;
        bif.data = {8'h00, 8'hFF};
        mlast    = N - 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs", 32'({bif.grant, bif.busy, bif.bit_out, bif.bit_valid,
                                        bif.done, bif.done_id, bif.hit_count}), 0);
        end
        reset = 1'b1;
        do_word(2'b11, 8'hFF, 8'h00, 1, 0);
        check("first_edge_grant", 32'(last_wait), 1);

        do_word(2'b10, 8'h00, 8'hF7, 1, 0);
        do_word(2'b10, 8'h00, 8'h77, 1, 0);
        do_word(2'b10, 8'h00, 8'h7E, 1, 0);
        do_word(2'b10, 8'h00, 8'h00, 1, 0);

        for (int k = 0; k < 4; k++)
            do_word(2'b11, 8'($urandom), 8'($urandom), 0, k > 0);

        // Abort a word from requester 0 in its 4th SHIFT cycle.
        bif.req  = 2'b00;
        tick();
        tick();
        bif.req  = 2'b01;
        bif.data = {8'h00, 8'hFF};
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            tick();
            if (bif.grant != '0) got = 1'b1;
        end
        check("abort_grant_seen", 32'(got), 1);
        bif.req = 2'b00;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("abort_outputs", 32'({bif.grant, bif.busy, bif.bit_valid, bif.done}), 0);
        mlast = N - 1;
        nd = 0;
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bif.done) nd++;
        end
        check("abort_no_done", 32'(nd), 0);
        do_word(2'b10, 8'h00, 8'hF0, 1, 0);
        do_word(2'b11, 8'h3C, 8'hFF, 1, 0);

        do_word(2'b10, 8'h00, 8'h07, 1, 0);
        do_word(2'b10, 8'h00, 8'hC0, 1, 0);

        for (int r = 0; r < 16; r++) begin
            bif.req = 2'b00;
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                tick();
                check("idle_quiet", 32'({bif.grant, bif.busy, bif.done}), 0);
            end
            rq = 2'($urandom_range(1, 3));
            do_word(rq, 8'($urandom | $urandom), 8'($urandom | $urandom), 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
